// File: rtl/fifo_rd_stream_adapter.sv
// Adapts a fixed-latency FIFO read port to a valid/ready stream via credit-based reads into a skid buffer.
// Optional build macro FIFO_RD_STREAM_STATS_EN adds beat_count / stall_count outputs.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH      = 64,
  parameter int READ_LATENCY    = 2,
  parameter int SKID_DEPTH_BITS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_enable,
  input  logic                       fifo_empty,
  output logic                       fifo_re,
  input  logic                       fifo_valid,
  input  logic [DATA_WIDTH-1:0]      fifo_dout,
  output logic                       m_valid,
  output logic [DATA_WIDTH-1:0]      m_data,
  input  logic                       m_ready,
  output logic [SKID_DEPTH_BITS:0]   occupancy,
  output logic [1:0]                 err
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]                beat_count,
  output logic [31:0]                stall_count
`endif
);

  localparam int DEPTH = 1 << SKID_DEPTH_BITS;
  localparam int CW    = SKID_DEPTH_BITS + 1;
  localparam logic [CW:0]              DEPTH_WIDE = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]            DEPTH_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]            CNT_ONE    = CW'(1);
  localparam logic [SKID_DEPTH_BITS-1:0] PTR_ONE  = SKID_DEPTH_BITS'(1);

  if (DEPTH < READ_LATENCY + 1) begin : g_depth_check
    $error("fifo_rd_stream_adapter: skid depth too small for READ_LATENCY");
  end

  logic [CW-1:0]              r_inflight;
  logic [CW-1:0]              r_skid_count;
  logic [SKID_DEPTH_BITS-1:0] r_wr_ptr;
  logic [SKID_DEPTH_BITS-1:0] r_rd_ptr;
  logic [1:0]                 r_err;
  logic [DATA_WIDTH-1:0]      r_mem [DEPTH];

  logic [CW:0] w_outstanding;
  logic        w_issue;
  logic        w_skid_full;
  logic        w_inflight_zero;
  logic        w_valid_ok;
  logic        w_push;
  logic        w_pop;

  // Credits count every word that will still need a skid slot, so a returned word always fits.
  assign w_outstanding   = {1'b0, r_inflight} + {1'b0, r_skid_count};
  assign w_issue         = rd_enable & ~fifo_empty & ~reset & (w_outstanding < DEPTH_WIDE);
  assign w_skid_full     = (r_skid_count == DEPTH_CNT);
  assign w_inflight_zero = (r_inflight == '0);
  assign w_valid_ok      = fifo_valid & ~w_inflight_zero;
  assign w_push          = w_valid_ok & ~w_skid_full;
  assign w_pop           = m_valid & m_ready;

  assign fifo_re   = w_issue;
  assign m_valid   = (r_skid_count != '0);
  assign m_data    = r_mem[r_rd_ptr];
  assign occupancy = w_outstanding[CW-1:0];
  assign err       = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight   <= '0;
      r_skid_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_err        <= '0;
    end else begin
      // A stray strobe with nothing in flight is not a returned read, so it never touches the credit.
      if (w_issue && !w_valid_ok) begin
        r_inflight <= r_inflight + CNT_ONE;
      end else if (!w_issue && w_valid_ok) begin
        r_inflight <= r_inflight - CNT_ONE;
      end

      if (w_push && !w_pop) begin
        r_skid_count <= r_skid_count + CNT_ONE;
      end else if (!w_push && w_pop) begin
        r_skid_count <= r_skid_count - CNT_ONE;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end

      if (fifo_valid && w_skid_full) begin
        r_err[0] <= 1'b1;
      end
      if (fifo_valid && w_inflight_zero) begin
        r_err[1] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= fifo_dout;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] r_beat_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop) begin
        r_beat_count <= r_beat_count + 32'd1;
      end
      if (m_valid && !m_ready) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign beat_count  = r_beat_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: source FIFO model with fixed read latency plus an ordered scoreboard.
module tb_fifo_rd_stream_adapter;
  localparam int DW    = 64;
  localparam int RL    = 2;
  localparam int SDB   = 2;
  localparam int DEPTH = 1 << SDB;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_enable;
  logic          fifo_empty;
  logic          fifo_re;
  logic          fifo_valid;
  logic [DW-1:0] fifo_dout;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [SDB:0]  occupancy;
  logic [1:0]    err;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]   beat_count;
  logic [31:0]   stall_count;
`endif

  fifo_rd_stream_adapter #(
    .DATA_WIDTH(DW), .READ_LATENCY(RL), .SKID_DEPTH_BITS(SDB)
  ) dut (
    .clk(clk), .reset(reset), .rd_enable(rd_enable), .fifo_empty(fifo_empty),
    .fifo_re(fifo_re), .fifo_valid(fifo_valid), .fifo_dout(fifo_dout),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .occupancy(occupancy), .err(err)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .beat_count(beat_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [DW-1:0] d; } ret_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  ret_t          ret_q[$];
  int            cyc = 0;
  int            issued = 0, returned = 0, accepted = 0;
  bit            chk_en = 1'b1;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            re_cyc[$];
  int            beat_cyc[$];
  logic [DW-1:0] beat_dat[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    re_cyc.delete(); beat_cyc.delete(); beat_dat.delete();
  endtask

  task automatic clear_model();
    src_q.delete(); exp_q.delete(); ret_q.delete();
    issued = 0; returned = 0; accepted = 0; prev_stall = 1'b0;
    fifo_valid = 1'b0;
  endtask

  task automatic preload(input int n);
    for (int i = 1; i <= n; i++) src_q.push_back(DW'(i));
  endtask

  // One clock cycle: called just after a falling edge.
  task automatic step();
    logic          re_s, pop_s, v_s;
    logic [DW-1:0] w;
    fifo_empty = (src_q.size() == 0);
    #1;
    if (chk_en) begin
      check("fifo_re", 64'(fifo_re),
            64'(rd_enable && src_q.size() > 0 && (issued - accepted) < DEPTH));
      check("occupancy", 64'(occupancy), 64'(issued - accepted));
      check("m_valid", 64'(m_valid), 64'((returned - accepted) > 0));
      check("err_clean", 64'(err), 64'(0));
      if (prev_stall) begin
        check("hold_valid", 64'(m_valid), 64'(1));
        check("hold_data", m_data, prev_data);
      end
    end
    re_s = fifo_re; pop_s = m_valid & m_ready; v_s = fifo_valid;
    if (re_s) begin
      if (src_q.size() > 0) begin
        w = src_q.pop_front();
        exp_q.push_back(w);
        ret_q.push_back('{cyc + RL, w});
      end
      issued++;
      re_cyc.push_back(cyc);
    end
    if (v_s) returned++;
    if (pop_s) begin
      check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) check("m_data", m_data, exp_q.pop_front());
      accepted++;
      beat_cyc.push_back(cyc);
      beat_dat.push_back(m_data);
    end
    prev_stall = m_valid & ~m_ready;
    prev_data  = m_data;
    @(posedge clk);
    #1;
    cyc++;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      ret_t r;
      r = ret_q.pop_front();
      fifo_valid = 1'b1;
      fifo_dout  = r.d;
    end else begin
      fifo_valid = 1'b0;
      fifo_dout  = {$urandom, $urandom};
    end
    fifo_empty = (src_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    #1;
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_fifo_re", 64'(fifo_re), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    fifo_empty = (src_q.size() == 0);
  endtask

  initial begin
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] bc0;
`endif
    reset = 1'b1; rd_enable = 1'b1; fifo_empty = 1'b0; fifo_valid = 1'b0;
    fifo_dout = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_fifo_re", 64'(fifo_re), 64'(0));
    check("reset_m_valid", 64'(m_valid), 64'(0));
    check("reset_occupancy", 64'(occupancy), 64'(0));
    check("reset_err", 64'(err), 64'(0));
    reset = 1'b0;
    clear_model();

    // Streaming at full rate.
    clear_logs();
    preload(8);
    steps(16);
    check("t1_reads", 64'(re_cyc.size()), 64'(8));
    check("t1_reads_back2back", 64'(re_cyc[7] - re_cyc[0]), 64'(7));
    check("t1_beats", 64'(beat_dat.size()), 64'(8));
    for (int i = 0; i < beat_dat.size(); i++) begin
      check("t1_data", beat_dat[i], 64'(i + 1));
      check("t1_beat_cycle", 64'(beat_cyc[i] - beat_cyc[0]), 64'(i));
    end
    check("t1_latency", 64'(beat_cyc[0] - re_cyc[0]), 64'(RL + 1));
    check("t1_err", 64'(err), 64'(0));

    // Consumer stalled: credits limit reads to the skid depth.
    clear_logs();
    clear_model();
    m_ready = 1'b0;
    preload(10);
    steps(8);
    check("t2_reads", 64'(re_cyc.size()), 64'(DEPTH));
    check("t2_occupancy", 64'(occupancy), 64'(DEPTH));
    check("t2_m_valid", 64'(m_valid), 64'(1));
    check("t2_m_data", m_data, 64'(1));
    m_ready = 1'b1;
    steps(20);
    check("t2_beats", 64'(beat_dat.size()), 64'(10));
    for (int i = 0; i < beat_dat.size(); i++) check("t2_data", beat_dat[i], 64'(i + 1));

    // Toggling ready.
    clear_logs();
    clear_model();
`ifdef FIFO_RD_STREAM_STATS_EN
    bc0 = beat_count;
`endif
    preload(16);
    for (int i = 0; i < 48; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    check("t3_beats", 64'(beat_dat.size()), 64'(16));
    for (int i = 0; i < beat_dat.size(); i++) check("t3_data", beat_dat[i], 64'(i + 1));
`ifdef FIFO_RD_STREAM_STATS_EN
    check("t3_beat_count", 64'(beat_count - bc0), 64'(16));
`endif

    // Single word in the source FIFO.
    clear_logs();
    clear_model();
    m_ready = 1'b1;
    preload(1);
    steps(8);
    check("t4_reads", 64'(re_cyc.size()), 64'(1));
    check("t4_beats", 64'(beat_dat.size()), 64'(1));
    check("t4_empty", 64'(fifo_empty), 64'(1));
    check("t4_occupancy", 64'(occupancy), 64'(0));

    // Randomized traffic followed by a bounded drain.
    clear_logs();
    clear_model();
    for (int i = 0; i < 600; i++) begin
      if (src_q.size() < 20 && ($urandom % 3) != 0) src_q.push_back({$urandom, $urandom});
      m_ready   = (($urandom % 4) != 0);
      rd_enable = (($urandom % 8) != 0);
      step();
    end
    m_ready = 1'b1; rd_enable = 1'b1;
    for (int i = 0; i < 300 && (src_q.size() > 0 || exp_q.size() > 0); i++) step();
    check("rand_drained", 64'(exp_q.size() + src_q.size()), 64'(0));
    check("rand_occupancy", 64'(occupancy), 64'(0));

    // Reset with words both in flight and in the skid buffer.
    clear_model();
    m_ready = 1'b0;
    preload(10);
    steps(3);
    check("t5_pre_occupancy", 64'(occupancy), 64'(3));
    do_reset();
    clear_logs();
    rd_enable = 1'b0;
    m_ready   = 1'b1;
    preload(3);
    steps(5);
    check("t5_no_output", 64'(beat_dat.size()), 64'(0));
    rd_enable = 1'b1;
    steps(10);
    check("t5_beats", 64'(beat_dat.size()), 64'(3));
    for (int i = 0; i < beat_dat.size(); i++) check("t5_data", beat_dat[i], 64'(i + 1));

    // Unexpected returned-data strobe.
    chk_en    = 1'b0;
    rd_enable = 1'b0;
    fifo_valid = 1'b1;
    fifo_dout  = 64'hDEAD_BEEF;
    @(negedge clk);
    fifo_valid = 1'b0;
    #1;
    check("t6_err1", 64'(err[1]), 64'(1));
    check("t6_m_valid", 64'(m_valid), 64'(0));
    repeat (5) @(negedge clk);
    #1;
    check("t6_err1_sticky", 64'(err[1]), 64'(1));
    check("t6_err0", 64'(err[0]), 64'(0));
    check("t6_m_valid_later", 64'(m_valid), 64'(0));
    check("t6_occupancy", 64'(occupancy), 64'(0));
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1);
  end
endmodule
